// File: rtl/gradient_nms.sv
// Canny stage: central-difference gradient, 3-point non-maximum suppression and
// hysteresis thresholding on a streaming line of smoothed samples.
module gradient_nms #(
  parameter int DATA_W  = 8,
  parameter int HIGH_TH = 40,
  parameter int LOW_TH  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              line_start,
  input  logic [DATA_W-1:0] SmoothedIn,
  output logic [DATA_W-1:0] GradMag,
  output logic              GradSign,
  output logic              EdgeFlag,
  output logic              out_valid
);

  // Handshake: no backpressure. A sample is taken on every rising clk with
  // enb=1; line_start only matters on such an edge. out_valid is a one-cycle
  // strobe after an accepting edge that completed an interior pixel.

  localparam logic [DATA_W-1:0] HI_T = DATA_W'(HIGH_TH);
  localparam logic [DATA_W-1:0] LO_T = DATA_W'(LOW_TH);

  logic [DATA_W-1:0] xr1, xr2;
  logic [DATA_W-1:0] mr1, mr2;
  logic              sr1;
  logic [2:0]        cnt;
  logic              chain;

  logic [DATA_W:0]   g, g_neg;
  logic [DATA_W-1:0] mnew;
  logic              snew;
  logic              keep, is_strong, is_weak, edge_now, emit;

  always_comb begin
    g     = {1'b0, SmoothedIn} - {1'b0, xr2};
    g_neg = -g;
    snew  = g[DATA_W];
    mnew  = snew ? g_neg[DATA_W-1:0] : g[DATA_W-1:0];
    // Strict on the left, non-strict on the right: first position of a plateau wins.
    keep      = (mr1 > mr2) && (mr1 >= mnew);
    is_strong = keep && (mr1 >= HI_T);
    is_weak   = keep && (mr1 >= LO_T) && !is_strong;
    edge_now  = is_strong || (is_weak && chain);
    emit      = enb && !line_start && (cnt == 3'd4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xr1       <= '0;
      xr2       <= '0;
      mr1       <= '0;
      mr2       <= '0;
      sr1       <= 1'b0;
      cnt       <= 3'd0;
      chain     <= 1'b0;
      GradMag   <= '0;
      GradSign  <= 1'b0;
      EdgeFlag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (enb) begin
        if (line_start) begin
          cnt   <= 3'd1;
          xr2   <= xr1;
          xr1   <= SmoothedIn;
          mr1   <= '0;
          mr2   <= '0;
          sr1   <= 1'b0;
          chain <= 1'b0;
        end else begin
          xr2 <= xr1;
          xr1 <= SmoothedIn;
          mr2 <= mr1;
          mr1 <= mnew;
          sr1 <= snew;
          if (cnt != 3'd4) cnt <= cnt + 3'd1;
          if (emit) begin
            out_valid <= 1'b1;
            GradMag   <= keep ? mr1 : '0;
            GradSign  <= sr1;
            EdgeFlag  <= edge_now;
            // Chain breaks on any sub-LOW magnitude, suppressed or not.
            if (edge_now)        chain <= 1'b1;
            else if (mr1 < LO_T) chain <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gradient_nms.sv
// Directed bench for gradient_nms: hand-computed per-pixel magnitude, sign and
// edge expectations for step, plateau, hysteresis and line-control cases.
module tb_gradient_nms;

  logic       clk;
  logic       reset;
  logic       enb;
  logic       line_start;
  logic [7:0] SmoothedIn;
  logic [7:0] GradMag;
  logic       GradSign;
  logic       EdgeFlag;
  logic       out_valid;

  int passed = 0;
  int total  = 0;

  logic [7:0] xs[$];
  logic [7:0] exp_q[$];

  gradient_nms #(.DATA_W(8), .HIGH_TH(40), .LOW_TH(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .enb        (enb),
    .line_start (line_start),
    .SmoothedIn (SmoothedIn),
    .GradMag    (GradMag),
    .GradSign   (GradSign),
    .EdgeFlag   (EdgeFlag),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] x, input logic ls);
    @(negedge clk);
    enb        = 1'b1;
    line_start = ls;
    SmoothedIn = x;
    @(posedge clk);
    #1;
    enb        = 1'b0;
    line_start = 1'b0;
  endtask

  task automatic idle(input logic ls);
    @(negedge clk);
    enb        = 1'b0;
    line_start = ls;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  // Sample k produces pixel k-2 from k>=4; bit i of signs/edges is pixel i+2.
  task automatic run_line(input string tag, input logic first_ls, input int gap_at,
                          input logic [15:0] signs, input logic [15:0] edges);
    for (int k = 0; k < xs.size(); k++) begin
      if (k == gap_at) begin
        idle(1'b1);
        chk1($sformatf("%s gap valid", tag), out_valid, 1'b0);
      end
      send(xs[k], first_ls && (k == 0));
      if (k >= 4) begin
        chk1($sformatf("%s px%0d valid", tag, k - 2), out_valid, 1'b1);
        chk8($sformatf("%s px%0d mag", tag, k - 2), GradMag, exp_q.pop_front());
        chk1($sformatf("%s px%0d sign", tag, k - 2), GradSign, signs[k-4]);
        chk1($sformatf("%s px%0d edge", tag, k - 2), EdgeFlag, edges[k-4]);
      end else begin
        chk1($sformatf("%s k%0d novalid", tag, k), out_valid, 1'b0);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    enb        = 1'b0;
    line_start = 1'b0;
    SmoothedIn = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk8("reset mag", GradMag, 8'd0);
    chk1("reset sign", GradSign, 1'b0);
    chk1("reset edge", EdgeFlag, 1'b0);
    chk1("reset valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Four samples of a line never reach an interior pixel.
    xs = '{8'd10, 8'd20, 8'd30, 8'd40};
    exp_q = {};
    run_line("short", 1'b1, -1, 16'h0000, 16'h0000);

    // Partial rising step, then hold, then asynchronous reset mid-line.
    xs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200};
    exp_q = '{8'd0, 8'd200};
    run_line("pre_rst", 1'b1, -1, 16'h0000, 16'h0002);
    idle(1'b0);
    chk1("hold valid", out_valid, 1'b0);
    chk8("hold mag", GradMag, 8'd200);
    chk1("hold edge", EdgeFlag, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk8("midrst mag", GradMag, 8'd0);
    chk1("midrst edge", EdgeFlag, 1'b0);
    chk1("midrst valid", out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // No line_start after reset: counts as a line starting at k=0.
    xs = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    exp_q = '{8'd0};
    run_line("post_rst", 1'b0, -1, 16'h0000, 16'h0000);

    // Flat line, with a line_start on an enb=0 cycle that must be ignored.
    xs = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100,
           8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    exp_q = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_line("flat", 1'b1, 6, 16'h0000, 16'h0000);

    xs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 8'd200};
    exp_q = '{8'd0, 8'd200, 8'd0, 8'd0};
    run_line("rise", 1'b1, -1, 16'h0000, 16'h0002);

    xs = '{8'd200, 8'd200, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_q = '{8'd0, 8'd200, 8'd0, 8'd0};
    run_line("fall", 1'b1, -1, 16'h0006, 16'h0002);

    xs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd70, 8'd80, 8'd90, 8'd80, 8'd90};
    exp_q = '{8'd0, 8'd50, 8'd0, 8'd0, 8'd30, 8'd0, 8'd0};
    run_line("hyst_acc", 1'b1, -1, 16'h0000, 16'h0012);

    xs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50, 8'd60, 8'd80, 8'd80, 8'd80, 8'd80};
    exp_q = '{8'd0, 8'd50, 8'd0, 8'd0, 8'd30, 8'd0, 8'd0};
    run_line("hyst_rej", 1'b1, -1, 16'h0000, 16'h0002);

    // Leave chain set, then restart mid-line: a weak maximum at pixel 2 must not pass.
    xs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd50, 8'd50};
    exp_q = '{8'd0, 8'd50};
    run_line("chain_pre", 1'b1, -1, 16'h0000, 16'h0002);
    xs = '{8'd0, 8'd0, 8'd0, 8'd20, 8'd20, 8'd20};
    exp_q = '{8'd20, 8'd0};
    run_line("restart", 1'b1, -1, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
